// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-to-serial pattern detector controller with match counter and sticky irq
// Optional: define SEQ_DET_CTRL_LSB_FIRST_EN to serialize words LSB first (default MSB first).
module seq_det_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    input  logic              cnt_clr,
    output logic              irq,
    input  logic              irq_clr,
    output logic              busy
);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SEEN_W = $clog2(PAT_W + 1);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1101);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [IDX_W-1:0]   r_idx;
    logic [PAT_W-1:0]   r_hist;
    logic [SEEN_W-1:0]  r_seen;
    logic [PAT_W-1:0]   r_pattern;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_threshold;
    logic               r_in_ready;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;
    logic               r_irq;

    logic               w_bit;
    logic               w_consume;
    logic [PAT_W-1:0]   w_new_hist;
    logic               w_hit;
    logic               w_inc;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_irq_set;
    logic               w_last;
    logic               w_cfg_ok;
    logic               w_accept;

`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
    assign w_bit = r_shreg[0];
`else
    assign w_bit = r_shreg[DATA_W-1];
`endif

    assign w_consume  = (r_state == ST_SHIFT);
    assign w_new_hist = {r_hist[PAT_W-2:0], w_bit};
    assign w_hit      = w_consume && (w_new_hist == r_pattern) && (r_seen >= SEEN_W'(PAT_W - 1));
    // A hit alongside cnt_clr restarts the count at 1 and still counts as an increment.
    assign w_inc      = w_hit && (cnt_clr || !(&r_count));
    assign w_cnt_next = cnt_clr ? CNT_W'(1) : r_count + CNT_W'(1);
    assign w_irq_set  = w_inc && (w_cnt_next == r_threshold) && (r_threshold != '0);
    assign w_last     = (r_idx == IDX_W'(DATA_W - 1));
    assign w_cfg_ok   = cfg_we && (r_state == ST_IDLE);
    assign w_accept   = in_valid && r_in_ready && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_hist      <= '0;
            r_seen      <= '0;
            r_pattern   <= PAT_RST;
            r_overlap   <= 1'b1;
            r_threshold <= CNT_W'(1);
            r_in_ready  <= 1'b0;
            r_match     <= 1'b0;
            r_count     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_match <= w_hit;

            if (w_inc) begin
                r_count <= w_cnt_next;
            end else if (cnt_clr) begin
                r_count <= '0;
            end

            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_cfg_ok) begin
                        r_pattern   <= cfg_pattern;
                        r_overlap   <= cfg_overlap;
                        r_threshold <= cfg_threshold;
                        r_hist      <= '0;
                        r_seen      <= '0;
                    end
                    if (w_accept) begin
                        r_shreg    <= in_data;
                        r_idx      <= '0;
                        r_state    <= ST_SHIFT;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
                    r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
`else
                    r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
`endif
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_hit && !r_overlap) begin
                        r_hist <= '0;
                        r_seen <= '0;
                    end else begin
                        r_hist <= w_new_hist;
                        if (r_seen != SEEN_W'(PAT_W)) begin
                            r_seen <= r_seen + SEEN_W'(1);
                        end
                    end
                    if (w_last) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign bit_out     = w_consume & w_bit;
    assign match       = r_match;
    assign match_count = r_count;
    assign irq         = r_irq;
    assign busy        = w_consume;

endmodule
